// File: rtl/draw_pkg.sv
// Shared definitions for the draw write-back engine: FSM encoding,
// byte-enable constants and the burst sizing helper.
package draw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_REQ   = 3'd2,
        ST_DATA  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_FIN   = 3'd5
    } state_t;

    localparam logic [7:0] BE_FULL       = 8'hFF;
    localparam logic [7:0] BE_HALF       = 8'hF0;
    localparam int         MAX_BURST_DEF = 16;

    // Beats in the next burst: never more than max_burst, never past the line end.
    function automatic logic [4:0] burst_beats(input logic [11:0] words_left, input int max_burst);
        if (words_left > 12'(max_burst)) begin
            return 5'(max_burst);
        end
        return words_left[4:0];
    endfunction

endpackage

// File: rtl/draw_wrback_addr.sv
// Address, line and word bookkeeping for draw_wrback: tracks the current burst
// address/length, words left in the line and lines left in the blit.
module draw_wrback_addr
    import draw_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic        clr,
    input  logic        load,
    input  logic        beat,
    input  logic        next_line,
    input  logic [31:0] reg_dst_addr,
    input  logic [15:0] reg_dst_stride,
    input  logic [11:0] reg_width,
    input  logic [11:0] reg_height,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_len,
    output logic        burst_end,
    output logic        line_end,
    output logic        last_line,
    output logic        half_word
);

    logic [31:0] line_addr_q, line_addr_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] stride_q, stride_d;
    logic [11:0] wpl_q, wpl_d;
    logic [11:0] words_left_q, words_left_d;
    logic [11:0] lines_left_q, lines_left_d;
    logic [4:0]  beats_left_q, beats_left_d;
    logic [3:0]  len_q, len_d;
    logic        odd_q, odd_d;

    logic [11:0] wpl_in;
    logic [4:0]  beats;
    logic [4:0]  len_p1;
    logic [31:0] next_line_addr;

    always_comb begin
        line_addr_d  = line_addr_q;
        addr_d       = addr_q;
        stride_d     = stride_q;
        wpl_d        = wpl_q;
        words_left_d = words_left_q;
        lines_left_d = lines_left_q;
        beats_left_d = beats_left_q;
        len_d        = len_q;
        odd_d        = odd_q;
        beats        = '0;
        wpl_in       = 12'((13'(reg_width) + 13'd1) >> 1);
        len_p1       = {1'b0, len_q} + 5'd1;
        next_line_addr = line_addr_q + {16'd0, stride_q};

        if (clr) begin
            line_addr_d  = '0;
            addr_d       = '0;
            stride_d     = '0;
            wpl_d        = '0;
            words_left_d = '0;
            lines_left_d = '0;
            beats_left_d = '0;
            len_d        = '0;
            odd_d        = 1'b0;
        end else if (load) begin
            beats        = burst_beats(wpl_in, MAX_BURST);
            line_addr_d  = reg_dst_addr;
            addr_d       = reg_dst_addr;
            stride_d     = reg_dst_stride;
            wpl_d        = wpl_in;
            words_left_d = wpl_in;
            lines_left_d = reg_height;
            beats_left_d = beats;
            len_d        = 4'(beats - 5'd1);
            odd_d        = reg_width[0];
        end else if (beat) begin
            words_left_d = words_left_q - 12'd1;
            beats_left_d = beats_left_q - 5'd1;
            // Burst finished with words still pending in this line: queue the next burst.
            if (beats_left_q == 5'd1 && words_left_q != 12'd1) begin
                beats        = burst_beats(words_left_q - 12'd1, MAX_BURST);
                addr_d       = addr_q + {24'd0, len_p1, 3'b000};
                beats_left_d = beats;
                len_d        = 4'(beats - 5'd1);
            end
        end else if (next_line) begin
            beats        = burst_beats(wpl_q, MAX_BURST);
            line_addr_d  = next_line_addr;
            addr_d       = next_line_addr;
            words_left_d = wpl_q;
            lines_left_d = lines_left_q - 12'd1;
            beats_left_d = beats;
            len_d        = 4'(beats - 5'd1);
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            line_addr_q  <= '0;
            addr_q       <= '0;
            stride_q     <= '0;
            wpl_q        <= '0;
            words_left_q <= '0;
            lines_left_q <= '0;
            beats_left_q <= '0;
            len_q        <= '0;
            odd_q        <= 1'b0;
        end else begin
            line_addr_q  <= line_addr_d;
            addr_q       <= addr_d;
            stride_q     <= stride_d;
            wpl_q        <= wpl_d;
            words_left_q <= words_left_d;
            lines_left_q <= lines_left_d;
            beats_left_q <= beats_left_d;
            len_q        <= len_d;
            odd_q        <= odd_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_len   = len_q;
    assign burst_end = (beats_left_q == 5'd1);
    assign line_end  = (words_left_q == 12'd1);
    assign last_line = (lines_left_q == 12'd1);
    assign half_word = odd_q && (words_left_q == 12'd1);

endmodule

// File: rtl/draw_wrback.sv
// Draw write-back engine: pops pixel pairs from a FWFT FIFO and writes them as
// line-bounded bursts. Stall counter built only with DRAW_WRBACK_PERF_EN defined.
//
// state | meaning
// IDLE  | waiting for START
// CHECK | validate and latch blit registers
// REQ   | burst request held until MEM_ACK
// DATA  | stream burst beats from FIFO to memory
// NEXT  | advance to next line or finish
// FIN   | one-cycle DONE pulse
module draw_wrback
    import draw_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic        INIT,
    input  logic        START,
    input  logic [31:0] REG_DST_ADDR,
    input  logic [15:0] REG_DST_STRIDE,
    input  logic [11:0] REG_WIDTH,
    input  logic [11:0] REG_HEIGHT,
    input  logic [63:0] WR_DATA,
    input  logic        WR_EMPTY,
    output logic        WR_RD,
    output logic        MEM_REQ,
    input  logic        MEM_ACK,
    output logic [31:0] MEM_ADDR,
    output logic [3:0]  MEM_LEN,
    output logic        MEM_WVALID,
    input  logic        MEM_WREADY,
    output logic [63:0] MEM_WDATA,
    output logic [7:0]  MEM_BE,
    output logic        BUSY,
    output logic        DONE,
    output logic [1:0]  ERROR,
    output logic [31:0] PERF_STALL
);

    state_t      state_q, state_d;
    logic [1:0]  error_q, error_d;
    logic [1:0]  err_chk;
    logic        load, beat, next_line, wvalid;
    logic        burst_end, line_end, last_line, half_word;

    always_comb begin
        state_d   = state_q;
        error_d   = error_q;
        load      = 1'b0;
        beat      = 1'b0;
        next_line = 1'b0;
        wvalid    = 1'b0;
        err_chk   = {(REG_DST_ADDR[2:0] != 3'd0) || (REG_DST_STRIDE[2:0] != 3'd0),
                     (REG_WIDTH == 12'd0) || (REG_HEIGHT == 12'd0)};

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_CHECK;
                    error_d = 2'b00;
                end
            end
            ST_CHECK: begin
                error_d = err_chk;
                if (err_chk != 2'b00) begin
                    state_d = ST_FIN;
                end else begin
                    load    = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (MEM_ACK) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                wvalid = !WR_EMPTY;
                if (wvalid && MEM_WREADY) begin
                    beat = 1'b1;
                    if (burst_end) begin
                        state_d = line_end ? ST_NEXT : ST_REQ;
                    end
                end
            end
            ST_NEXT: begin
                if (last_line) begin
                    state_d = ST_FIN;
                end else begin
                    next_line = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // INIT aborts everything, including a beat handshake in flight.
        if (INIT) begin
            state_d   = ST_IDLE;
            error_d   = 2'b00;
            load      = 1'b0;
            beat      = 1'b0;
            next_line = 1'b0;
            wvalid    = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q <= ST_IDLE;
            error_q <= 2'b00;
        end else begin
            state_q <= state_d;
            error_q <= error_d;
        end
    end

    draw_wrback_addr #(.MAX_BURST(MAX_BURST)) u_addr (
        .CLK            (CLK),
        .RST_X          (RST_X),
        .clr            (INIT),
        .load           (load),
        .beat           (beat),
        .next_line      (next_line),
        .reg_dst_addr   (REG_DST_ADDR),
        .reg_dst_stride (REG_DST_STRIDE),
        .reg_width      (REG_WIDTH),
        .reg_height     (REG_HEIGHT),
        .mem_addr       (MEM_ADDR),
        .mem_len        (MEM_LEN),
        .burst_end      (burst_end),
        .line_end       (line_end),
        .last_line      (last_line),
        .half_word      (half_word)
    );

    assign MEM_REQ    = (state_q == ST_REQ);
    assign MEM_WVALID = wvalid;
    assign WR_RD      = beat;
    assign MEM_WDATA  = (state_q == ST_DATA) ? WR_DATA : 64'd0;
    assign MEM_BE     = (state_q != ST_DATA) ? 8'h00 : (half_word ? BE_HALF : BE_FULL);
    assign BUSY       = (state_q != ST_IDLE);
    assign DONE       = (state_q == ST_FIN);
    assign ERROR      = error_q;

`ifdef DRAW_WRBACK_PERF_EN
    logic [31:0] perf_q, perf_d;
    logic        start_acc;

    assign start_acc = (state_q == ST_IDLE) && START && !INIT;

    always_comb begin
        perf_d = perf_q;
        if (INIT || start_acc) begin
            perf_d = '0;
        end else if (state_q == ST_DATA && (WR_EMPTY || !MEM_WREADY) && perf_q != 32'hFFFF_FFFF) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign PERF_STALL = perf_q;
`else
    assign PERF_STALL = 32'd0;
`endif

endmodule

// File: tb/tb_draw_wrback.sv
// Self-checking bench for draw_wrback: table vectors, random blits against a
// line/burst reference model, plus reset, INIT-abort and restart sequences.
module tb_draw_wrback;

    localparam int SRC_N = 4096;

    logic        CLK, RST_X, INIT, START;
    logic [31:0] REG_DST_ADDR;
    logic [15:0] REG_DST_STRIDE;
    logic [11:0] REG_WIDTH, REG_HEIGHT;
    logic [63:0] WR_DATA;
    logic        WR_EMPTY, WR_RD;
    logic        MEM_REQ, MEM_ACK;
    logic [31:0] MEM_ADDR;
    logic [3:0]  MEM_LEN;
    logic        MEM_WVALID, MEM_WREADY;
    logic [63:0] MEM_WDATA;
    logic [7:0]  MEM_BE;
    logic        BUSY, DONE;
    logic [1:0]  ERROR;
    logic [31:0] PERF_STALL;

    draw_wrback dut (
        .CLK(CLK), .RST_X(RST_X), .INIT(INIT), .START(START),
        .REG_DST_ADDR(REG_DST_ADDR), .REG_DST_STRIDE(REG_DST_STRIDE),
        .REG_WIDTH(REG_WIDTH), .REG_HEIGHT(REG_HEIGHT),
        .WR_DATA(WR_DATA), .WR_EMPTY(WR_EMPTY), .WR_RD(WR_RD),
        .MEM_REQ(MEM_REQ), .MEM_ACK(MEM_ACK), .MEM_ADDR(MEM_ADDR), .MEM_LEN(MEM_LEN),
        .MEM_WVALID(MEM_WVALID), .MEM_WREADY(MEM_WREADY), .MEM_WDATA(MEM_WDATA), .MEM_BE(MEM_BE),
        .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .PERF_STALL(PERF_STALL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] stride;
        logic [11:0] w;
        logic [11:0] h;
        int          emode;      // 0 never empty, 1 toggling, 2 random
        int          rmode;      // 0 always ready, 1 random, 2 three-cycle drop mid-burst
        int          ackd;
        int          restart_at; // cycle offset of a stray START, 0 = none
        logic [1:0]  exp_err;
        int          exp_bursts;
        int          exp_pops;
    } vec_t;

    typedef struct packed { logic [31:0] addr; logic [3:0] len; } burst_t;
    typedef struct packed { logic [63:0] data; logic [7:0] be; } beat_t;

    burst_t act_b[$], exp_b[$];
    beat_t  act_w[$], exp_w[$];
    logic [63:0] src [SRC_N];

    int n_checks = 0, n_fail = 0;
    int emode, rmode, ackd;
    int cyc = 0, outstanding, data_cyc, req_wait, src_idx, stall_cnt, viol;
    int done_cnt, done_cyc, first_req;
    logic [31:0] hold_addr;
    logic [3:0]  hold_len;
    logic [1:0]  err_at_done;

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    // Reference: lines of ceil(W/2) words, split into bursts of at most 16 beats.
    task automatic build_model(input vec_t v, output logic [1:0] e);
        logic [31:0] la;
        int wpl, k, n;
        burst_t b;
        beat_t  w;
        exp_b.delete();
        exp_w.delete();
        e = {(v.addr[2:0] != 3'd0) || (v.stride[2:0] != 3'd0), (v.w == 12'd0) || (v.h == 12'd0)};
        if (e == 2'b00) begin
            wpl = (int'(v.w) + 1) / 2;
            k = 0;
            for (int l = 0; l < int'(v.h); l++) begin
                la = v.addr + 32'(l) * 32'(v.stride);
                for (int off = 0; off < wpl; off += n) begin
                    n = (wpl - off > 16) ? 16 : wpl - off;
                    b.addr = la + 32'(off * 8);
                    b.len  = 4'(n - 1);
                    exp_b.push_back(b);
                    for (int i = 0; i < n; i++) begin
                        w.data = src[k];
                        w.be   = ((off + i == wpl - 1) && v.w[0]) ? 8'hF0 : 8'hFF;
                        exp_w.push_back(w);
                        k++;
                    end
                end
            end
        end
    endtask

    task automatic clear_track();
        outstanding = 0; data_cyc = 0; req_wait = 0; src_idx = 0; stall_cnt = 0; viol = 0;
        done_cnt = 0; done_cyc = -1; first_req = -1;
        act_b.delete();
        act_w.delete();
    endtask

    // One clock: drive at negedge, observe 1ns later; handshakes complete at the next posedge.
    task automatic step(input logic start_p, input logic init_p);
        logic   in_data;
        burst_t b;
        beat_t  w;
        @(negedge CLK);
        START = start_p;
        INIT  = init_p;
        case (emode)
            0:       WR_EMPTY = 1'b0;
            1:       WR_EMPTY = cyc[0];
            default: WR_EMPTY = ($urandom_range(0, 3) == 0);
        endcase
        if (src_idx >= SRC_N) WR_EMPTY = 1'b1;
        WR_DATA = src[src_idx % SRC_N];
        case (rmode)
            0:       MEM_WREADY = 1'b1;
            1:       MEM_WREADY = ($urandom_range(0, 2) != 0);
            default: MEM_WREADY = !(data_cyc >= 5 && data_cyc < 8);
        endcase
        MEM_ACK = MEM_REQ && (req_wait >= ackd);
        #1;
        in_data = (outstanding > 0);
        if (in_data) begin
            data_cyc++;
            if (WR_EMPTY || !MEM_WREADY) stall_cnt++;
        end
        if (MEM_WVALID != (in_data && !WR_EMPTY && !INIT)) viol++;
        if (WR_RD && WR_EMPTY) viol++;
        if (WR_RD != (MEM_WVALID && MEM_WREADY)) viol++;
        if (MEM_WVALID && MEM_WREADY) begin
            w.data = MEM_WDATA;
            w.be   = MEM_BE;
            act_w.push_back(w);
            outstanding--;
        end
        if (WR_RD) src_idx++;
        if (MEM_REQ) begin
            if (outstanding > 0) viol++;
            if (req_wait > 0 && (MEM_ADDR != hold_addr || MEM_LEN != hold_len)) viol++;
            hold_addr = MEM_ADDR;
            hold_len  = MEM_LEN;
            if (first_req < 0) first_req = cyc;
            if (MEM_ACK) begin
                b.addr = MEM_ADDR;
                b.len  = MEM_LEN;
                act_b.push_back(b);
                outstanding += int'(MEM_LEN) + 1;
                req_wait = 0;
            end else begin
                req_wait++;
            end
        end
        if (DONE) begin
            done_cnt++;
            done_cyc    = cyc;
            err_at_done = ERROR;
        end
        cyc++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"},    64'(MEM_REQ), 64'd0);
        check({tag, "_mem_addr"},   64'(MEM_ADDR), 64'd0);
        check({tag, "_mem_len"},    64'(MEM_LEN), 64'd0);
        check({tag, "_mem_wvalid"}, 64'(MEM_WVALID), 64'd0);
        check({tag, "_mem_wdata"},  MEM_WDATA, 64'd0);
        check({tag, "_mem_be"},     64'(MEM_BE), 64'd0);
        check({tag, "_wr_rd"},      64'(WR_RD), 64'd0);
        check({tag, "_busy"},       64'(BUSY), 64'd0);
        check({tag, "_done"},       64'(DONE), 64'd0);
        check({tag, "_error"},      64'(ERROR), 64'd0);
        check({tag, "_perf"},       64'(PERF_STALL), 64'd0);
    endtask

    task automatic setup_job(input vec_t v);
        for (int i = 0; i < SRC_N; i++) src[i] = {$urandom, $urandom};
        emode = v.emode; rmode = v.rmode; ackd = v.ackd;
        REG_DST_ADDR = v.addr; REG_DST_STRIDE = v.stride;
        REG_WIDTH = v.w; REG_HEIGHT = v.h;
        clear_track();
    endtask

    task automatic run_job(input vec_t v, input logic use_tbl);
        logic [1:0] e;
        int start_c, k, bad, nmin;
        setup_job(v);
        build_model(v, e);
        start_c = cyc;
        step(1'b1, 1'b0);
        k = 1;
        while (done_cnt == 0 && k < 6000) begin
            step((v.restart_at != 0) && (k == v.restart_at), 1'b0);
            if (k == 1) begin
                check("start_clears_error", 64'(ERROR), 64'd0);
                check("busy_in_check", 64'(BUSY), 64'd1);
            end
            if (k == 2) begin
                // Registers must already be latched; scramble them.
                REG_DST_ADDR = $urandom; REG_DST_STRIDE = 16'($urandom);
                REG_WIDTH = 12'($urandom); REG_HEIGHT = 12'($urandom);
            end
            k++;
        end
        step(1'b0, 1'b0);
        check("busy_after_fin", 64'(BUSY), 64'd0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("error_held", 64'(ERROR), 64'(e));
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("error_at_done", 64'(err_at_done), 64'(e));
        if (e != 2'b00) check("err_done_latency", 64'(done_cyc - start_c), 64'd2);
        else            check("first_req_latency", 64'(first_req - start_c), 64'd2);
        check("burst_count", 64'(act_b.size()), 64'(exp_b.size()));
        nmin = (act_b.size() < exp_b.size()) ? act_b.size() : exp_b.size();
        for (int i = 0; i < nmin; i++) begin
            check("burst_addr", 64'(act_b[i].addr), 64'(exp_b[i].addr));
            check("burst_len",  64'(act_b[i].len),  64'(exp_b[i].len));
        end
        check("beat_count", 64'(act_w.size()), 64'(exp_w.size()));
        nmin = (act_w.size() < exp_w.size()) ? act_w.size() : exp_w.size();
        bad = 0;
        for (int i = 0; i < nmin; i++) if (act_w[i] != exp_w[i]) bad++;
        check("beat_data_be_mismatches", 64'(bad), 64'd0);
        check("pop_count", 64'(src_idx), 64'(exp_w.size()));
        check("protocol_violations", 64'(viol), 64'd0);
`ifdef DRAW_WRBACK_PERF_EN
        check("perf_stall", 64'(PERF_STALL), 64'(stall_cnt));
`else
        check("perf_stall_zero", 64'(PERF_STALL), 64'd0);
`endif
        if (use_tbl) begin
            check("tbl_error", 64'(ERROR), 64'(v.exp_err));
            check("tbl_bursts", 64'(act_b.size()), 64'(v.exp_bursts));
            check("tbl_pops", 64'(src_idx), 64'(v.exp_pops));
        end
    endtask

    vec_t tbl[11];
    vec_t rv;

    initial begin
        //           addr          stride    w      h      em rm ack rs  err    bursts pops
        tbl[0]  = '{32'h0000_1000, 16'h0400, 12'd64,   12'd2, 0, 0, 0, 0,  2'b00, 4,   64};
        tbl[1]  = '{32'h0000_2000, 16'h0040, 12'd5,    12'd1, 0, 0, 0, 0,  2'b00, 1,   3};
        tbl[2]  = '{32'h0000_3000, 16'h0040, 12'd0,    12'd3, 0, 0, 0, 0,  2'b01, 0,   0};
        tbl[3]  = '{32'h0000_1004, 16'h0040, 12'd4,    12'd1, 0, 0, 0, 0,  2'b10, 0,   0};
        tbl[4]  = '{32'h0000_1000, 16'h0404, 12'd0,    12'd1, 0, 0, 0, 0,  2'b11, 0,   0};
        tbl[5]  = '{32'h0000_0100, 16'h0008, 12'd1,    12'd1, 0, 0, 0, 0,  2'b00, 1,   1};
        tbl[6]  = '{32'h0000_0500, 16'h0100, 12'd33,   12'd3, 2, 1, 1, 10, 2'b00, 6,   51};
        tbl[7]  = '{32'h0000_8000, 16'h0010, 12'd32,   12'd2, 1, 1, 5, 3,  2'b00, 2,   32};
        tbl[8]  = '{32'hFFFF_FF80, 16'h0100, 12'd10,   12'd2, 0, 0, 2, 0,  2'b00, 2,   10};
        tbl[9]  = '{32'h0000_4000, 16'h0100, 12'd40,   12'd1, 1, 2, 0, 0,  2'b00, 2,   20};
        tbl[10] = '{32'h0001_0000, 16'h2000, 12'd4095, 12'd1, 0, 0, 0, 0,  2'b00, 128, 2048};

        // Reset with live-looking inputs: every output must stay at zero.
        RST_X = 1'b0; INIT = 1'b0; START = 1'b1;
        REG_DST_ADDR = 32'h1000; REG_DST_STRIDE = 16'h400; REG_WIDTH = 12'd8; REG_HEIGHT = 12'd1;
        WR_DATA = {$urandom, $urandom}; WR_EMPTY = 1'b0; MEM_ACK = 1'b1; MEM_WREADY = 1'b1;
        emode = 0; rmode = 0; ackd = 0;
        clear_track();
        repeat (3) @(negedge CLK);
        #1;
        check_all_zero("reset");
        @(negedge CLK);
        RST_X = 1'b1; START = 1'b0; MEM_ACK = 1'b0;
        step(1'b0, 1'b0);
        check_all_zero("post_reset");

        for (int i = 0; i < 11; i++) run_job(tbl[i], 1'b1);

        // INIT in the middle of a burst aborts with no DONE and clean outputs.
        setup_job(tbl[0]);
        step(1'b1, 1'b0);
        for (int i = 0; i < 200 && act_w.size() < 10; i++) step(1'b0, 1'b0);
        check("init_reached_data", 64'(act_w.size() >= 10), 64'd1);
        step(1'b0, 1'b1);
        outstanding = 0; req_wait = 0;
        step(1'b0, 1'b0);
        check_all_zero("after_init");
        check("init_no_done", 64'(done_cnt), 64'd0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        check("init_over_start_busy", 64'(BUSY), 64'd0);
        run_job(tbl[1], 1'b1);

        // Error result survives idle time, then a good blit clears it.
        run_job(tbl[3], 1'b1);
        repeat (5) step(1'b0, 1'b0);
        check("error_idle_hold", 64'(ERROR), 64'd2);
        run_job(tbl[5], 1'b1);

        for (int r = 0; r < 20; r++) begin
            rv.addr = $urandom;
            if ($urandom_range(0, 4) != 0) rv.addr[2:0] = 3'd0;
            rv.stride = 16'($urandom);
            if ($urandom_range(0, 4) != 0) rv.stride[2:0] = 3'd0;
            rv.w = 12'($urandom_range(0, 40));
            rv.h = 12'($urandom_range(0, 4));
            rv.emode = $urandom_range(0, 2);
            rv.rmode = $urandom_range(0, 1);
            rv.ackd = $urandom_range(0, 3);
            rv.restart_at = ($urandom_range(0, 1) != 0) ? $urandom_range(3, 12) : 0;
            rv.exp_err = 2'b00; rv.exp_bursts = -1; rv.exp_pops = -1;
            run_job(rv, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
